// File: rtl/seq_mon_pkg.sv
// -----------------------------------------------------------------------------
// seq_mon_pkg
// Shared definitions for the sequence event monitor:
//   - burst_state_t : burst tracker states
//   - DEF_*         : default parameter values for seq_event_monitor
//   - RUN_W         : width of the burst run counter (holds up to 15)
// -----------------------------------------------------------------------------
package seq_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } burst_state_t;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_GAP_W   = 8;
    localparam int DEF_BURST_N = 3;
    localparam int DEF_WIN     = 16;

    localparam int RUN_W = 4;

endpackage

// File: rtl/seq_event_monitor_gap_timer.sv
// -----------------------------------------------------------------------------
// gap_timer
// Counts cycles since the most recent event.
// Ports:
//   clk   : clock, rising edge
//   clear : synchronous clear to 0 (reset or soft clear)
//   load  : event this cycle, timer restarts at 1
//   value : current timer value, saturates at all-ones
// -----------------------------------------------------------------------------
module gap_timer #(
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    output logic [GAP_W-1:0] value
);

    // Loading 1 on the event cycle makes the value seen at the next event
    // equal to the distance between the two event edges.
    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= GAP_W'(1);
        end else if (value != '1) begin
            value <= value + GAP_W'(1);
        end
    end

endmodule

// File: rtl/seq_event_monitor.sv
// -----------------------------------------------------------------------------
// seq_event_monitor
// Counts events from an upstream sequence detector, records the gap of each
// event through a valid/ack handshake, flags dropped records, and pulses when
// BURST_N events arrive each within WIN cycles of the previous one.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   det_in    : one event per cycle sampled high
//   clr       : synchronous soft clear, same effect as rst, beats det_in
//   rd_ack    : consumer takes the current record
//   evt_count : saturating event count
//   rec_valid : record available
//   rec_gap   : gap of the recorded event (0 for first event after clear)
//   overflow  : sticky, a record was dropped
//   burst     : one-cycle burst detection pulse
// -----------------------------------------------------------------------------
module seq_event_monitor
    import seq_mon_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int BURST_N = DEF_BURST_N,
    parameter int WIN     = DEF_WIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_in,
    input  logic             clr,
    input  logic             rd_ack,
    output logic [CNT_W-1:0] evt_count,
    output logic             rec_valid,
    output logic [GAP_W-1:0] rec_gap,
    output logic             overflow,
    output logic             burst
);

    localparam logic [GAP_W-1:0] WIN_L   = GAP_W'(WIN);
    localparam logic [RUN_W-1:0] BURST_L = RUN_W'(BURST_N);

    logic             clear;
    logic [GAP_W-1:0] timer;
    logic [GAP_W-1:0] gap_now;
    logic             first_evt;
    logic             in_win;

    burst_state_t     state, state_next;
    logic [RUN_W-1:0] run, run_next;
    logic             burst_next;

    assign clear   = rst | clr;
    assign gap_now = first_evt ? '0 : timer;
    assign in_win  = (timer <= WIN_L);

    gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk   (clk),
        .clear (clear),
        .load  (det_in),
        .value (timer)
    );

    // Counter, first-event flag and record handshake. A pending record is
    // only replaced when the consumer acks in the same cycle; otherwise the
    // new event is dropped and overflow latches.
    always_ff @(posedge clk) begin
        if (clear) begin
            evt_count <= '0;
            first_evt <= 1'b1;
            rec_valid <= 1'b0;
            rec_gap   <= '0;
            overflow  <= 1'b0;
        end else if (det_in) begin
            if (evt_count != '1) begin
                evt_count <= evt_count + CNT_W'(1);
            end
            first_evt <= 1'b0;
            if (!rec_valid || rd_ack) begin
                rec_gap   <= gap_now;
                rec_valid <= 1'b1;
            end else begin
                overflow  <= 1'b1;
            end
        end else if (rd_ack) begin
            rec_valid <= 1'b0;
        end
    end

    // Burst tracker state register; burst is registered here so the pulse
    // appears the cycle after the completing event.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
            run   <= '0;
            burst <= 1'b0;
        end else begin
            state <= state_next;
            run   <= run_next;
            burst <= burst_next;
        end
    end

    // Burst tracker next state. The timer value in an event cycle is the gap
    // to the previous event; in a quiet cycle it is the time elapsed so far.
    always_comb begin
        state_next = state;
        run_next   = run;
        burst_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (det_in) begin
                    state_next = ST_RUN;
                    run_next   = RUN_W'(1);
                end
            end
            ST_RUN: begin
                if (det_in) begin
                    if (in_win) begin
                        run_next = run + RUN_W'(1);
                        if (run + RUN_W'(1) == BURST_L) begin
                            burst_next = 1'b1;
                            state_next = ST_LOCK;
                        end
                    end else begin
                        run_next = RUN_W'(1);
                    end
                end else if (!in_win) begin
                    state_next = ST_IDLE;
                    run_next   = '0;
                end
            end
            ST_LOCK: begin
                if (det_in) begin
                    if (!in_win) begin
                        state_next = ST_RUN;
                        run_next   = RUN_W'(1);
                    end
                end else if (!in_win) begin
                    state_next = ST_IDLE;
                    run_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                run_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_event_monitor.sv
// -----------------------------------------------------------------------------
// tb_seq_event_monitor
// Self-checking bench for seq_event_monitor with default parameters.
// A behavioural model tracks the absolute cycle of the last event and the
// length of the current burst, and every cycle is compared after the edge.
// -----------------------------------------------------------------------------
module tb_seq_event_monitor;

    localparam int CNT_W   = 8;
    localparam int GAP_W   = 8;
    localparam int BURST_N = 3;
    localparam int WIN     = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int GAP_MAX = (1 << GAP_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             det_in = 1'b0;
    logic             clr = 1'b0;
    logic             rd_ack = 1'b0;
    logic [CNT_W-1:0] evt_count;
    logic             rec_valid;
    logic [GAP_W-1:0] rec_gap;
    logic             overflow;
    logic             burst;

    int compared   = 0;
    int mismatched = 0;

    int m_cyc      = 0;
    int m_last     = 0;
    bit m_has_prev = 0;
    int m_count    = 0;
    bit m_valid    = 0;
    int m_gap      = 0;
    bit m_ovf      = 0;
    bit m_burst    = 0;
    int m_run      = 0;
    bit m_locked   = 0;

    seq_event_monitor #(
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W),
        .BURST_N (BURST_N),
        .WIN     (WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .det_in    (det_in),
        .clr       (clr),
        .rd_ack    (rd_ack),
        .evt_count (evt_count),
        .rec_valid (rec_valid),
        .rec_gap   (rec_gap),
        .overflow  (overflow),
        .burst     (burst)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s @edge %0d: observed %0d, expected %0d",
                     tag, m_cyc, observed, expected);
        end
    endtask

    // Model of one clock edge: events are judged by how many cycles have
    // passed since the previous event, not by any timer or state encoding.
    task automatic modelStep(input bit d, input bit c, input bit r, input bit a);
        int raw;
        int gap;
        m_cyc++;
        m_burst = 0;
        if (r || c) begin
            m_has_prev = 0;
            m_count    = 0;
            m_valid    = 0;
            m_gap      = 0;
            m_ovf      = 0;
            m_run      = 0;
            m_locked   = 0;
        end else if (d) begin
            raw = m_cyc - m_last;
            gap = !m_has_prev ? 0 : (raw > GAP_MAX ? GAP_MAX : raw);
            if (m_count < CNT_MAX) m_count++;
            if (!m_valid || a) begin
                m_gap   = gap;
                m_valid = 1;
            end else begin
                m_ovf = 1;
            end
            if (!m_has_prev || raw > WIN) begin
                m_run    = 1;
                m_locked = 0;
            end else if (!m_locked) begin
                m_run++;
                if (m_run == BURST_N) begin
                    m_burst  = 1;
                    m_locked = 1;
                end
            end
            m_has_prev = 1;
            m_last     = m_cyc;
        end else if (a) begin
            m_valid = 0;
        end
    endtask

    task automatic applyStimulus(input bit d, input bit c, input bit r, input bit a);
        @(negedge clk);
        det_in = d;
        clr    = c;
        rst    = r;
        rd_ack = a;
        @(posedge clk);
        modelStep(d, c, r, a);
        #1;
        checkOutput("evt_count", 32'(evt_count), 32'(m_count));
        checkOutput("rec_valid", 32'(rec_valid), 32'(m_valid));
        checkOutput("rec_gap",   32'(rec_gap),   32'(m_gap));
        checkOutput("overflow",  32'(overflow),  32'(m_ovf));
        checkOutput("burst",     32'(burst),     32'(m_burst));
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
    endtask

    initial begin
        int bursts;
        int density;

        // Reset state
        doReset();
        checkOutput("reset_count", 32'(evt_count), 32'd0);
        checkOutput("reset_valid", 32'(rec_valid), 32'd0);

        // Three events at 10, 14, 19, each record taken the next cycle
        for (int e = 1; e <= 25; e++)
            applyStimulus(e == 10 || e == 14 || e == 19, 0, 0,
                          e == 11 || e == 15 || e == 20);
        checkOutput("s1_count", 32'(evt_count), 32'd3);

        // Second event dropped while the first record is pending
        doReset();
        for (int e = 1; e <= 45; e++)
            applyStimulus(e == 10 || e == 40, 0, 0, 0);
        checkOutput("s2_ovf", 32'(overflow), 32'd1);
        checkOutput("s2_gap", 32'(rec_gap), 32'd0);
        checkOutput("s2_count", 32'(evt_count), 32'd2);
        for (int e = 46; e <= 52; e++)
            applyStimulus(0, 0, 0, e == 50);
        checkOutput("s2_valid", 32'(rec_valid), 32'd0);

        // Event coinciding with ack replaces the record without overflow
        doReset();
        for (int e = 1; e <= 22; e++)
            applyStimulus(e == 10 || e == 20, 0, 0, e == 20);
        checkOutput("s3_valid", 32'(rec_valid), 32'd1);
        checkOutput("s3_gap", 32'(rec_gap), 32'd10);
        checkOutput("s3_ovf", 32'(overflow), 32'd0);

        // Burst, lock, expiry, second burst
        doReset();
        bursts = 0;
        for (int e = 1; e <= 50; e++) begin
            applyStimulus(e == 10 || e == 14 || e == 18 || e == 22 ||
                          e == 40 || e == 42 || e == 44, 0, 0, 1);
            if (burst === 1'b1) bursts++;
        end
        checkOutput("s4_bursts", 32'(bursts), 32'd2);

        // Counter saturation, then clear beating a simultaneous event
        doReset();
        for (int e = 0; e < 900; e++)
            applyStimulus(e % 3 == 0, 0, 0, 1);
        checkOutput("s5_sat", 32'(evt_count), 32'(CNT_MAX));
        applyStimulus(1, 1, 0, 0);
        checkOutput("s5_clr_count", 32'(evt_count), 32'd0);
        checkOutput("s5_clr_valid", 32'(rec_valid), 32'd0);

        // Gap saturation after a long quiet period
        doReset();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        for (int e = 0; e < 300; e++)
            applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("s6_gap", 32'(rec_gap), 32'(GAP_MAX));

        // Randomized traffic with varying event density
        doReset();
        density = 20;
        for (int e = 0; e < 3000; e++) begin
            if (e % 200 == 0) density = (e / 200) % 3 == 0 ? 5 : ((e / 200) % 3 == 1 ? 25 : 60);
            applyStimulus($urandom_range(0, 99) < density,
                          $urandom_range(0, 199) == 0,
                          $urandom_range(0, 399) == 0,
                          $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
